calib_hit_gen: RTL and testbench

CALIB_HIT_GEN -- requirements
Module: calib_hit_gen

---
 rtl/tdc_pkg.sv | 19 +
 rtl/lfsr16.sv | 31 +++
 rtl/calib_hit_gen.sv | 168 ++++++++++++++++
 tb/tb_calib_hit_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared state encoding and LFSR constants for the calibration hit generator.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 as a mask over value[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step whenever step is high.
module lfsr16
    import tdc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (step) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/calib_hit_gen.sv
// Calibration hit generator: emits bursts of fixed-width hits with
// programmable spacing and optional LFSR jitter towards the TDC input filter.
module calib_hit_gen
    import tdc_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int LEN_W    = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    input  logic [LEN_W-1:0]    pulse_len,
    input  logic [CNT_W-1:0]    burst_count,
    input  logic                rand_en,
    output logic                hit,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    hit_count
);

    localparam int GAP_W = PERIOD_W + 1;

    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                rst_int_n;
    state_t              state_q, state_d;
    logic [GAP_W-1:0]    cnt_q, cnt_d;
    logic                hit_q, hit_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [LEN_W-1:0]    plen_q, plen_d;
    logic [CNT_W-1:0]    burst_q, burst_d;
    logic                rand_q, rand_d;
    logic                lfsr_step;
    logic [15:0]         lfsr_value;
    logic [11:0]         lfsr_unused;
    logic [GAP_W-1:0]    plen_eff, start_plen_eff, gap_len;
    logic [CNT_W-1:0]    hit_count_inc;

    // Reset asserts asynchronously but is released two clk edges later
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_int_n),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    assign lfsr_unused = lfsr_value[15:4];

    // Gap math is one bit wider than period so adding jitter cannot wrap
    always_comb begin
        plen_eff       = (plen_q == '0) ? GAP_W'(1) : GAP_W'(plen_q);
        start_plen_eff = (pulse_len == '0) ? GAP_W'(1) : GAP_W'(pulse_len);
        gap_len        = ({1'b0, period_q} > plen_eff) ? ({1'b0, period_q} - plen_eff) : GAP_W'(1);
        if (rand_q) begin
            gap_len = gap_len + GAP_W'(lfsr_value[3:0]);
        end
        hit_count_inc = (&hit_count_q) ? hit_count_q : hit_count_q + CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hit_count_d = hit_count_q;
        period_d    = period_q;
        plen_d      = plen_q;
        burst_d     = burst_q;
        rand_d      = rand_q;
        lfsr_step   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && enable) begin
                    period_d    = period;
                    plen_d      = pulse_len;
                    burst_d     = burst_count;
                    rand_d      = rand_en;
                    hit_count_d = CNT_W'(1);
                    cnt_d       = start_plen_eff - GAP_W'(1);
                    lfsr_step   = 1'b1;
                    state_d     = PULSE;
                end
            end
            PULSE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = gap_len - GAP_W'(1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - GAP_W'(1);
                end
            end
            GAP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    if ((burst_q != '0) && (hit_count_q == burst_q)) begin
                        state_d = FIN;
                    end else begin
                        cnt_d       = plen_eff - GAP_W'(1);
                        hit_count_d = hit_count_inc;
                        lfsr_step   = 1'b1;
                        state_d     = PULSE;
                    end
                end else begin
                    cnt_d = cnt_q - GAP_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hit_d  = (state_d == PULSE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            done_q      <= 1'b0;
            hit_count_q <= '0;
            period_q    <= '0;
            plen_q      <= '0;
            burst_q     <= '0;
            rand_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            done_q      <= done_d;
            hit_count_q <= hit_count_d;
            period_q    <= period_d;
            plen_q      <= plen_d;
            burst_q     <= burst_d;
            rand_q      <= rand_d;
        end
    end

    assign hit       = hit_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_calib_hit_gen.sv
// Self-checking bench for calib_hit_gen: observed hit edges and done pulses
// are compared against a cycle-timeline model derived from the burst rules.
module tb_calib_hit_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic [15:0] period;
    logic [3:0]  pulse_len;
    logic [7:0]  burst_count;
    logic        rand_en;
    logic        hit;
    logic        busy;
    logic        done;
    logic [7:0]  hit_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rises[$];
    int falls[$];
    int dones[$];
    int exp_rise[$];
    int exp_fall[$];
    int exp_done;
    logic        hit_prev = 1'b0;
    logic [15:0] model_lfsr;

    calib_hit_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .start       (start),
        .period      (period),
        .pulse_len   (pulse_len),
        .burst_count (burst_count),
        .rand_en     (rand_en),
        .hit         (hit),
        .busy        (busy),
        .done        (done),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timeline monitor: cycle numbers of hit rises, falls and done pulses
    always @(negedge clk) begin
        if (hit === 1'b1 && hit_prev !== 1'b1) rises.push_back(cyc);
        if (hit !== 1'b1 && hit_prev === 1'b1) falls.push_back(cyc);
        if (done === 1'b1) dones.push_back(cyc);
        hit_prev = hit;
    end

    function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int p, input int l, input int b, input int r);
        period      = 16'(p);
        pulse_len   = 4'(l);
        burst_count = 8'(b);
        rand_en     = r[0];
        enable      = 1'b1;
        start       = 1'b1;
        rises.delete();
        falls.delete();
        dones.delete();
        start_cyc = cyc;
        tick(1);
        start       = 1'b0;
        period      = 16'($urandom);
        pulse_len   = 4'($urandom);
        burst_count = 8'($urandom);
        rand_en     = 1'($urandom);
    endtask

    // Expected timeline: spacing = max(len,1) + max(period-max(len,1),1) + jitter
    task automatic build_expect(input int p, input int l, input int b, input int r, input int n);
        int pl, gap, t;
        pl = (l == 0) ? 1 : l;
        t  = start_cyc + 1;
        exp_rise.delete();
        exp_fall.delete();
        for (int i = 0; i < n; i++) begin
            model_lfsr = lfsr_ref(model_lfsr);
            exp_rise.push_back(t);
            exp_fall.push_back(t + pl);
            gap = (p > pl) ? p - pl : 1;
            if (r != 0) gap += int'(model_lfsr[3:0]);
            t += pl + gap;
        end
        exp_done = (b != 0) ? t : -1;
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while (busy === 1'b1 && k < maxc) begin
            tick(1);
            k++;
        end
    endtask

    task automatic test_reset();
        enable = 1'b0; start = 1'b0; period = '0; pulse_len = '0;
        burst_count = '0; rand_en = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit got %b expected 0", hit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_hit_count got %0d expected 0", hit_count); end
        tick(2);
        rst_n = 1'b1;
        tick(4);
        model_lfsr = 16'hACE1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_busy got %b expected 0", busy); end
    endtask

    task automatic test_burst();
        start_burst(10, 3, 4, 0);
        build_expect(10, 3, 4, 0, 4);
        wait_idle(300);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL burst_timeout busy %b expected 0", busy); end
        checks++; if (rises.size() != 4) begin errors++; $display("[TB] FAIL burst_count got %0d expected 4", rises.size()); end
        for (int i = 0; i < 4; i++) begin
            int gr, gf;
            gr = (i < rises.size()) ? rises[i] : -1;
            gf = (i < falls.size()) ? falls[i] : -1;
            checks++; if (gr != exp_rise[i]) begin errors++; $display("[TB] FAIL burst_rise[%0d] got %0d expected %0d", i, gr, exp_rise[i]); end
            checks++; if (gf != exp_fall[i]) begin errors++; $display("[TB] FAIL burst_fall[%0d] got %0d expected %0d", i, gf, exp_fall[i]); end
        end
        checks++; if (dones.size() != 1 || dones[0] != exp_done) begin
            errors++; $display("[TB] FAIL burst_done count %0d first %0d expected one at %0d", dones.size(), (dones.size() > 0) ? dones[0] : -1, exp_done);
        end
        checks++; if (hit_count !== 8'd4) begin errors++; $display("[TB] FAIL burst_hit_count got %0d expected 4", hit_count); end
    endtask

    task automatic test_degenerate();
        start_burst(1, 0, 6, 0);
        build_expect(1, 0, 6, 0, 6);
        wait_idle(200);
        checks++; if (rises.size() != 6 || falls.size() != 6) begin
            errors++; $display("[TB] FAIL degen_count rises %0d falls %0d expected 6", rises.size(), falls.size());
        end
        for (int i = 0; i < rises.size() && i < falls.size(); i++) begin
            checks++; if (falls[i] - rises[i] != 1) begin errors++; $display("[TB] FAIL degen_width[%0d] got %0d expected 1", i, falls[i] - rises[i]); end
            if (i > 0) begin
                checks++; if (rises[i] - rises[i-1] != 2) begin errors++; $display("[TB] FAIL degen_spacing[%0d] got %0d expected 2", i, rises[i] - rises[i-1]); end
            end
        end
        checks++; if (dones.size() != 1 || dones[0] != exp_done) begin
            errors++; $display("[TB] FAIL degen_done count %0d expected one at %0d", dones.size(), exp_done);
        end
        checks++; if (hit_count !== 8'd6) begin errors++; $display("[TB] FAIL degen_hit_count got %0d expected 6", hit_count); end
    endtask

    task automatic test_jitter();
        start_burst(20, 2, 8, 1);
        build_expect(20, 2, 8, 1, 8);
        wait_idle(600);
        checks++; if (rises.size() != 8) begin errors++; $display("[TB] FAIL jitter_count got %0d expected 8", rises.size()); end
        for (int i = 1; i < rises.size() && i < 8; i++) begin
            int sp, esp;
            sp  = rises[i] - rises[i-1];
            esp = exp_rise[i] - exp_rise[i-1];
            checks++; if (sp < 20 || sp > 35) begin errors++; $display("[TB] FAIL jitter_range[%0d] got %0d expected 20..35", i, sp); end
            checks++; if (sp != esp) begin errors++; $display("[TB] FAIL jitter_spacing[%0d] got %0d expected %0d", i, sp, esp); end
        end
        checks++; if (dones.size() != 1 || dones[0] != exp_done) begin
            errors++; $display("[TB] FAIL jitter_done count %0d expected one at %0d", dones.size(), exp_done);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int p, l, b, r;
            p = int'($urandom_range(30, 1));
            l = int'($urandom_range(6, 0));
            b = int'($urandom_range(5, 1));
            r = int'($urandom_range(1, 0));
            start_burst(p, l, b, r);
            build_expect(p, l, b, r, b);
            wait_idle(2000);
            checks++; if (rises.size() != b) begin errors++; $display("[TB] FAIL rand%0d_count got %0d expected %0d", n, rises.size(), b); end
            for (int i = 0; i < b; i++) begin
                int gr, gf;
                gr = (i < rises.size()) ? rises[i] : -1;
                gf = (i < falls.size()) ? falls[i] : -1;
                checks++; if (gr != exp_rise[i] || gf != exp_fall[i]) begin
                    errors++; $display("[TB] FAIL rand%0d_hit[%0d] rise/fall got %0d/%0d expected %0d/%0d (p=%0d l=%0d r=%0d)", n, i, gr, gf, exp_rise[i], exp_fall[i], p, l, r);
                end
            end
            checks++; if (dones.size() != 1 || dones[0] != exp_done) begin
                errors++; $display("[TB] FAIL rand%0d_done count %0d expected one at %0d", n, dones.size(), exp_done);
            end
            checks++; if (hit_count !== 8'(b)) begin errors++; $display("[TB] FAIL rand%0d_hit_count got %0d expected %0d", n, hit_count, b); end
        end
    endtask

    task automatic test_abort();
        int k;
        start_burst(12, 4, 0, 0);
        build_expect(12, 4, 0, 0, 5);
        k = 0;
        while (rises.size() < 5 && k < 500) begin tick(1); k++; end
        checks++; if (rises.size() != 5 || cyc != exp_rise[4] + 1) begin
            errors++; $display("[TB] FAIL abort_reach rises %0d cycle %0d expected 5 at %0d", rises.size(), cyc, exp_rise[4] + 1);
        end
        enable = 1'b0;
        tick(1);
        checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL abort_hit got %b expected 0", hit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b expected 0", busy); end
        checks++; if (hit_count !== 8'd5) begin errors++; $display("[TB] FAIL abort_hit_count got %0d expected 5", hit_count); end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        checks++; if (dones.size() != 0) begin errors++; $display("[TB] FAIL abort_done got %0d pulses expected 0", dones.size()); end
        checks++; if (busy !== 1'b0 || rises.size() != 5) begin
            errors++; $display("[TB] FAIL abort_start_disabled busy %b rises %0d expected 0 and 5", busy, rises.size());
        end
        // enable and start rise together from a disabled idle state
        start_burst(6, 2, 2, 0);
        build_expect(6, 2, 2, 0, 2);
        wait_idle(100);
        checks++; if (rises.size() < 1 || rises[0] != exp_rise[0]) begin
            errors++; $display("[TB] FAIL same_cycle_first_rise got %0d expected %0d", (rises.size() > 0) ? rises[0] : -1, exp_rise[0]);
        end
        checks++; if (dones.size() != 1 || dones[0] != exp_done) begin
            errors++; $display("[TB] FAIL same_cycle_done count %0d expected one at %0d", dones.size(), exp_done);
        end
    endtask

    task automatic test_saturate();
        int k;
        start_burst(1, 1, 0, 0);
        build_expect(1, 1, 0, 0, 300);
        k = 0;
        while (rises.size() < 300 && k < 1000) begin tick(1); k++; end
        enable = 1'b0;
        tick(2);
        checks++; if (hit_count !== 8'hFF) begin errors++; $display("[TB] FAIL saturate_hit_count got %0d expected 255", hit_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL saturate_busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int k;
        start_burst(20, 3, 0, 0);
        k = 0;
        while (rises.size() < 1 && k < 50) begin tick(1); k++; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse_hit got %b expected 0", hit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse_busy got %b expected 0", busy); end
        tick(1);
        rst_n = 1'b1;
        tick(4);
        model_lfsr = 16'hACE1;
        start_burst(20, 3, 0, 0);
        k = 0;
        while (rises.size() < 1 && k < 50) begin tick(1); k++; end
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hit !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_gap_outputs hit/busy/done got %b/%b/%b expected 0/0/0", hit, busy, done);
        end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_gap_hit_count got %0d expected 0", hit_count); end
        tick(1);
        rst_n = 1'b1;
        tick(4);
        model_lfsr = 16'hACE1;
        checks++; if (busy !== 1'b0 || dones.size() != 0) begin
            errors++; $display("[TB] FAIL reset_gap_after busy %b dones %0d expected 0 and 0", busy, dones.size());
        end
    endtask

    task automatic test_back_to_back();
        int k;
        start_burst(10, 3, 3, 1);
        build_expect(10, 3, 3, 1, 3);
        k = 0;
        while (busy === 1'b1 && k < 300) begin
            start = (k == 4 || k == 14);
            if (start) begin
                period    = 16'($urandom_range(40, 2));
                pulse_len = 4'($urandom_range(9, 5));
            end
            tick(1);
            k++;
        end
        start = 1'b0;
        checks++; if (rises.size() != 3) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 3", rises.size()); end
        for (int i = 0; i < 3; i++) begin
            int gr, gf;
            gr = (i < rises.size()) ? rises[i] : -1;
            gf = (i < falls.size()) ? falls[i] : -1;
            checks++; if (gr != exp_rise[i] || gf != exp_fall[i]) begin
                errors++; $display("[TB] FAIL b2b_hit[%0d] rise/fall got %0d/%0d expected %0d/%0d", i, gr, gf, exp_rise[i], exp_fall[i]);
            end
        end
        checks++; if (dones.size() != 1 || dones[0] != exp_done) begin
            errors++; $display("[TB] FAIL b2b_done count %0d expected one at %0d", dones.size(), exp_done);
        end
        checks++; if (hit_count !== 8'd3) begin errors++; $display("[TB] FAIL b2b_hit_count got %0d expected 3", hit_count); end
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart busy %b expected 0", busy); end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_burst();
        test_degenerate();
        test_jitter();
        test_random();
        test_abort();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
